// File: rtl/aes_host_pkg.sv
// Shared encodings for the AES register-bus host controller: FSM states,
// register map and control/status bit positions.
package aes_host_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_KEY,
        S_WR_CFG,
        S_WR_INIT,
        S_GAP1,
        S_POLL_RDY,
        S_WR_BLK,
        S_WR_NEXT,
        S_GAP2,
        S_POLL_VLD,
        S_RD_RES,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_CONFIG  = 8'h0A;
    localparam logic [7:0] ADDR_KEY0    = 8'h10;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
    localparam logic [7:0] ADDR_RESULT0 = 8'h30;

    localparam int CTRL_INIT_BIT    = 0;
    localparam int CTRL_NEXT_BIT    = 1;
    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_VALID_BIT = 1;

    // word 0 is the most significant 32 bits
    function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] idx);
        return v[(3 - int'(idx)) * 32 +: 32];
    endfunction

endpackage

// File: rtl/aes_host_ctrl.sv
// Runs one AES-128 operation on the core's register bus: load key/config,
// init, wait ready, load block, next, wait valid, read the 128-bit result.
module aes_host_ctrl
    import aes_host_pkg::*;
#(
    parameter int POLL_MAX   = 1023,
    parameter int GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         encdec,
    input  logic [127:0] key_in,
    input  logic [127:0] block_in,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] result,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data
);

    localparam int PW = ($clog2(POLL_MAX + 1) > 10) ? $clog2(POLL_MAX + 1) : 10;
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    state_e         state_q, state_d;
    logic [1:0]     word_q, word_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   block_q, block_d;
    logic [127:0]   result_q, result_d;
    logic           encdec_q, encdec_d;
    logic           error_q, error_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cs_q, cs_d;
    logic           we_q, we_d;
    logic [7:0]     address_q, address_d;
    logic [31:0]    wdata_q, wdata_d;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        poll_d   = poll_q;
        gap_d    = gap_q;
        key_d    = key_q;
        block_d  = block_q;
        result_d = result_q;
        encdec_d = encdec_q;
        error_d  = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d    = key_in;
                    block_d  = block_in;
                    encdec_d = encdec;
                    result_d = '0;
                    error_d  = 1'b0;
                    word_d   = '0;
                    state_d  = S_WR_KEY;
                end
            end
            S_WR_KEY: begin
                word_d = word_q + 2'd1;
                if (word_q == 2'd3) state_d = S_WR_CFG;
            end
            S_WR_CFG: state_d = S_WR_INIT;
            S_WR_INIT: begin
                gap_d   = '0;
                poll_d  = '0;
                state_d = (GAP_CYCLES == 0) ? S_POLL_RDY : S_GAP1;
            end
            S_GAP1: begin
                gap_d = gap_q + GW'(1);
                if (int'(gap_q) == GAP_CYCLES - 1) state_d = S_POLL_RDY;
            end
            S_POLL_RDY: begin
                // a hit on the last allowed read still counts as success
                if (read_data[STATUS_READY_BIT] == 1'b1) begin
                    word_d  = '0;
                    state_d = S_WR_BLK;
                end else if (poll_q == PW'(POLL_MAX - 1)) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    poll_d = poll_q + PW'(1);
                end
            end
            S_WR_BLK: begin
                word_d = word_q + 2'd1;
                if (word_q == 2'd3) state_d = S_WR_NEXT;
            end
            S_WR_NEXT: begin
                gap_d   = '0;
                poll_d  = '0;
                state_d = (GAP_CYCLES == 0) ? S_POLL_VLD : S_GAP2;
            end
            S_GAP2: begin
                gap_d = gap_q + GW'(1);
                if (int'(gap_q) == GAP_CYCLES - 1) state_d = S_POLL_VLD;
            end
            S_POLL_VLD: begin
                if (read_data[STATUS_VALID_BIT] == 1'b1) begin
                    word_d  = '0;
                    state_d = S_RD_RES;
                end else if (poll_q == PW'(POLL_MAX - 1)) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    poll_d = poll_q + PW'(1);
                end
            end
            S_RD_RES: begin
                result_d = {result_q[95:0], read_data};
                word_d   = word_q + 2'd1;
                if (word_q == 2'd3) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus and status outputs are decoded from the next state so the flops
    // present each access in the same cycle the FSM sits in that state.
    always_comb begin
        cs_d      = 1'b0;
        we_d      = 1'b0;
        address_d = '0;
        wdata_d   = '0;
        busy_d    = !(state_d inside {S_IDLE, S_DONE, S_ERR});
        done_d    = (state_d == S_DONE);
        case (state_d)
            S_WR_KEY: begin
                cs_d      = 1'b1;
                we_d      = 1'b1;
                address_d = ADDR_KEY0 | {6'b0, word_d};
                wdata_d   = word_sel(key_d, word_d);
            end
            S_WR_CFG: begin
                cs_d      = 1'b1;
                we_d      = 1'b1;
                address_d = ADDR_CONFIG;
                wdata_d   = {30'b0, 1'b0, encdec_d};
            end
            S_WR_INIT: begin
                cs_d      = 1'b1;
                we_d      = 1'b1;
                address_d = ADDR_CTRL;
                wdata_d   = 32'(1) << CTRL_INIT_BIT;
            end
            S_POLL_RDY, S_POLL_VLD: begin
                cs_d      = 1'b1;
                address_d = ADDR_STATUS;
            end
            S_WR_BLK: begin
                cs_d      = 1'b1;
                we_d      = 1'b1;
                address_d = ADDR_BLOCK0 | {6'b0, word_d};
                wdata_d   = word_sel(block_d, word_d);
            end
            S_WR_NEXT: begin
                cs_d      = 1'b1;
                we_d      = 1'b1;
                address_d = ADDR_CTRL;
                wdata_d   = 32'(1) << CTRL_NEXT_BIT;
            end
            S_RD_RES: begin
                cs_d      = 1'b1;
                address_d = ADDR_RESULT0 | {6'b0, word_d};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            poll_q    <= '0;
            gap_q     <= '0;
            key_q     <= '0;
            block_q   <= '0;
            result_q  <= '0;
            encdec_q  <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            poll_q    <= poll_d;
            gap_q     <= gap_d;
            key_q     <= key_d;
            block_q   <= block_d;
            result_q  <= result_d;
            encdec_q  <= encdec_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_q      <= cs_d;
            we_q      <= we_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign result     = result_q;
    assign cs         = cs_q;
    assign we         = we_q;
    assign address    = address_q;
    assign write_data = wdata_q;

endmodule

// File: tb/tb_aes_host_ctrl.sv
// Directed bench for aes_host_ctrl with a behavioural AES register-file
// responder; a second instance with POLL_MAX=15 covers the poll timeout.
module tb_aes_host_ctrl;
    import aes_host_pkg::*;

    localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] B2 = 128'h8899aabbccddeeff0011223344556677;
    localparam logic [127:0] PAT = {4{32'hdeadbeef}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0, start_t = 1'b0, encdec = 1'b0;
    logic [127:0] key_in = '0, block_in = '0;
    logic         busy, done, error, cs, we;
    logic [127:0] result;
    logic [7:0]   address;
    logic [31:0]  write_data, read_data;
    logic         busy_t, done_t, error_t, cs_t, we_t;
    logic [127:0] result_t;
    logic [7:0]   address_t;
    logic [31:0]  write_data_t, read_data_t;

    aes_host_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .encdec(encdec), .key_in(key_in),
        .block_in(block_in), .busy(busy), .done(done), .error(error), .result(result),
        .cs(cs), .we(we), .address(address), .write_data(write_data), .read_data(read_data)
    );

    aes_host_ctrl #(.POLL_MAX(15)) dut_t (
        .clk(clk), .rst(rst), .start(start_t), .encdec(encdec), .key_in(key_in),
        .block_in(block_in), .busy(busy_t), .done(done_t), .error(error_t), .result(result_t),
        .cs(cs_t), .we(we_t), .address(address_t), .write_data(write_data_t),
        .read_data(read_data_t)
    );

    function automatic logic [127:0] aes_model(input logic [127:0] k, b, input logic e);
        if (e && k == K && b == P) return C;
        if (!e && k == K && b == C) return P;
        return b ^ k ^ PAT;
    endfunction

    // responder model for dut
    logic [127:0] m_key = '0, m_blk = '0, m_res = '0;
    logic [31:0]  m_cfg = '0;
    logic         m_rdy_arm = 1'b0, m_vld_arm = 1'b0;
    int           m_rdy_rd = 0, m_vld_rd = 0;
    int           rdy_delay = 0, vld_delay = 0;
    logic [7:0]   wl_addr [0:31];
    logic [31:0]  wl_data [0:31];
    int           wl_n = 0;
    logic         log_clr = 1'b1;

    always_comb begin
        read_data = 32'h0;
        if (cs && !we) begin
            if (address == ADDR_STATUS)
                read_data = {30'b0, (m_vld_arm && (m_vld_rd >= vld_delay)),
                             (m_rdy_arm && (m_rdy_rd >= rdy_delay))};
            else if (address >= 8'h30 && address <= 8'h33)
                read_data = m_res[(3 - int'(address[1:0])) * 32 +: 32];
        end
    end

    always @(posedge clk) begin
        if (log_clr) begin
            wl_n      <= 0;
            m_rdy_arm <= 1'b0;
            m_vld_arm <= 1'b0;
            m_rdy_rd  <= 0;
            m_vld_rd  <= 0;
        end else if (cs && we) begin
            if (wl_n < 32) begin
                wl_addr[wl_n] <= address;
                wl_data[wl_n] <= write_data;
            end
            wl_n <= wl_n + 1;
            if (address == ADDR_CONFIG) m_cfg <= write_data;
            else if (address == ADDR_CTRL) begin
                if (write_data[CTRL_INIT_BIT]) begin
                    m_rdy_arm <= 1'b1;
                    m_rdy_rd  <= 0;
                    m_vld_arm <= 1'b0;
                end
                if (write_data[CTRL_NEXT_BIT]) begin
                    m_vld_arm <= 1'b1;
                    m_vld_rd  <= 0;
                    m_res     <= aes_model(m_key, m_blk, m_cfg[0]);
                end
            end else if (address[7:4] == 4'h1)
                m_key[(3 - int'(address[1:0])) * 32 +: 32] <= write_data;
            else if (address[7:4] == 4'h2)
                m_blk[(3 - int'(address[1:0])) * 32 +: 32] <= write_data;
        end else if (cs && !we && address == ADDR_STATUS) begin
            if (m_vld_arm) m_vld_rd <= m_vld_rd + 1;
            else if (m_rdy_arm) m_rdy_rd <= m_rdy_rd + 1;
        end
    end

    // timeout instance: ready at once, valid never
    assign read_data_t = (cs_t && !we_t && address_t == ADDR_STATUS) ? 32'h1 : 32'h0;
    logic t_next_seen = 1'b0;
    int   t_vld_rd = 0;
    always @(posedge clk) begin
        if (log_clr) begin
            t_next_seen <= 1'b0;
            t_vld_rd    <= 0;
        end else if (cs_t && we_t && address_t == ADDR_CTRL && write_data_t[CTRL_NEXT_BIT]) begin
            t_next_seen <= 1'b1;
            t_vld_rd    <= 0;
        end else if (cs_t && !we_t && address_t == ADDR_STATUS && t_next_seen)
            t_vld_rd <= t_vld_rd + 1;
    end

    int done_seen = 0, done_t_seen = 0, viol = 0;
    always @(negedge clk) begin
        if (done) done_seen <= done_seen + 1;
        if (done_t) done_t_seen <= done_t_seen + 1;
        if ((cs && !busy) || (done && busy) || (cs_t && !busy_t) || (done_t && busy_t))
            viol <= viol + 1;
    end

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_writes(input string tag, input logic [127:0] k, b, input logic e);
        logic [7:0]  ea [11];
        logic [31:0] ed [11];
        logic ok;
        int bi;
        for (int i = 0; i < 4; i++) begin
            ea[i]     = 8'(16 + i);
            ed[i]     = k[(3 - i) * 32 +: 32];
            ea[6 + i] = 8'(32 + i);
            ed[6 + i] = b[(3 - i) * 32 +: 32];
        end
        ea[4] = 8'h0A; ed[4] = {31'b0, e};
        ea[5] = 8'h08; ed[5] = 32'h1;
        ea[10] = 8'h08; ed[10] = 32'h2;
        checks++;
        ok = (wl_n == 11);
        bi = -1;
        for (int i = 0; i < 11; i++)
            if (ok && (wl_addr[i] !== ea[i] || wl_data[i] !== ed[i])) begin
                ok = 1'b0;
                bi = i;
            end
        if (!ok) begin
            errors++;
            if (bi < 0) $display("FAIL %s writes: got %0d writes expected 11", tag, wl_n);
            else $display("FAIL %s writes: #%0d got %h=%h expected %h=%h", tag, bi,
                          wl_addr[bi], wl_data[bi], ea[bi], ed[bi]);
        end
    endtask

    // start on one cycle, then count cycles until done or error (bounded)
    task automatic run_op(input logic [127:0] k, b, input logic e,
                          output int lat, output logic b1);
        @(negedge clk);
        key_in = k; block_in = b; encdec = e; start = 1'b1; log_clr = 1'b1;
        @(negedge clk);
        start = 1'b0; log_clr = 1'b0;
        lat = 1;
        b1 = busy;
        while (lat < 400 && !done && !error) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] blk;
        logic         enc;
        int           rdy_d;
        int           vld_d;
        logic [127:0] exp_res;
        int           exp_lat;
        int           exp_rdy;
        int           exp_vld;
    } vec_t;

    vec_t vt [5];
    int   lat, v0;
    logic b1;

    initial begin
        vt[0] = '{K,  P,  1'b1, 0,  0,  C,             22, 1,  1};
        vt[1] = '{K,  C,  1'b0, 0,  0,  P,             22, 1,  1};
        vt[2] = '{K,  P,  1'b1, 37, 37, C,             96, 38, 38};
        vt[3] = '{K,  C,  1'b0, 3,  5,  P,             30, 4,  6};
        vt[4] = '{K2, B2, 1'b1, 1,  2,  B2 ^ K2 ^ PAT, 25, 2,  3};

        repeat (3) @(negedge clk);
        chk("reset_ctrl", 128'({busy, done, error, cs, we}), 128'(0));
        chk("reset_bus", 128'({address, write_data}), 128'(0));
        chk("reset_result", result, 128'(0));
        rst = 1'b0;
        log_clr = 1'b0;

        for (int i = 0; i < 5; i++) begin
            rdy_delay = vt[i].rdy_d;
            vld_delay = vt[i].vld_d;
            v0 = done_seen;
            run_op(vt[i].key, vt[i].blk, vt[i].enc, lat, b1);
            chk($sformatf("v%0d busy_after_start", i), 128'(b1), 128'(1));
            chk($sformatf("v%0d done", i), 128'({done, error, busy}), 128'(3'b100));
            chk($sformatf("v%0d latency", i), 128'(lat), 128'(vt[i].exp_lat));
            chk($sformatf("v%0d result", i), result, vt[i].exp_res);
            chk($sformatf("v%0d ready_reads", i), 128'(m_rdy_rd), 128'(vt[i].exp_rdy));
            chk($sformatf("v%0d valid_reads", i), 128'(m_vld_rd), 128'(vt[i].exp_vld));
            chk_writes($sformatf("v%0d", i), vt[i].key, vt[i].blk, vt[i].enc);
            @(negedge clk);
            chk($sformatf("v%0d single_pulse", i), 128'(done_seen - v0), 128'(1));
            chk($sformatf("v%0d result_held", i), result, vt[i].exp_res);
        end

        // start re-pulsed while busy with another key must be ignored
        rdy_delay = 0; vld_delay = 0;
        @(negedge clk);
        key_in = K; block_in = P; encdec = 1'b1; start = 1'b1; log_clr = 1'b1;
        @(negedge clk);
        start = 1'b0; log_clr = 1'b0; lat = 1;
        repeat (4) begin @(negedge clk); lat++; end
        key_in = K2; block_in = B2; encdec = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat++;
        while (lat < 400 && !done) begin @(negedge clk); lat++; end
        chk("rebusy latency", 128'(lat), 128'(22));
        chk("rebusy result", result, C);
        chk_writes("rebusy", K, P, 1'b1);

        // reset during the third block write
        @(negedge clk);
        key_in = K; block_in = P; encdec = 1'b1; start = 1'b1; log_clr = 1'b1;
        @(negedge clk);
        start = 1'b0; log_clr = 1'b0; lat = 1;
        repeat (11) begin @(negedge clk); lat++; end
        chk("rstmid pre", 128'({cs, we, address}), 128'({1'b1, 1'b1, 8'h22}));
        v0 = done_seen;
        #1 rst = 1'b1;
        #1 chk("rstmid async_drop", 128'({cs, we, busy, done}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rstmid no_done", 128'(done_seen - v0), 128'(0));
        chk("rstmid idle", 128'({busy, error, cs}), 128'(0));
        run_op(K, P, 1'b1, lat, b1);
        chk("rstmid fresh_latency", 128'(lat), 128'(22));
        chk("rstmid fresh_result", result, C);

        // start together with reset: reset wins
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start busy_cs", 128'({busy, cs, result}), 128'(0));

        // valid never set on the POLL_MAX=15 instance
        @(negedge clk);
        key_in = K; block_in = P; encdec = 1'b1; start_t = 1'b1; log_clr = 1'b1;
        @(negedge clk);
        start_t = 1'b0; log_clr = 1'b0; lat = 1; v0 = done_t_seen;
        while (lat < 400 && !error_t) begin @(negedge clk); lat++; end
        chk("timeout latency", 128'(lat), 128'(32));
        chk("timeout flags", 128'({error_t, busy_t, cs_t, done_t}), 128'(4'b1000));
        chk("timeout status_reads", 128'(t_vld_rd), 128'(15));
        repeat (5) @(negedge clk);
        chk("timeout sticky", 128'(error_t), 128'(1));
        chk("timeout no_done", 128'(done_t_seen - v0), 128'(0));
        start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        chk("timeout restart_clears", 128'({error_t, busy_t}), 128'(2'b01));
        lat = 0;
        while (lat < 400 && !error_t) begin @(negedge clk); lat++; end
        chk("timeout again", 128'(error_t), 128'(1));

        @(negedge clk);
        chk("cs_busy_done_protocol", 128'(viol), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
